// File: rtl/ap_pkg.sv
// Shared types and constants for the associative-processor host sequencer.
package ap_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_XOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_NOT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6
  } op_e;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] COL_A = 2'd0;
  localparam logic [1:0] COL_B = 2'd1;
  localparam logic [1:0] COL_C = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR0,
    ST_CLR1,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_COMPUTE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ap_host_timeout.sv
// Loadable down-counter guarding the wait for AP completion.
module ap_host_timeout #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(TIMEOUT_CYC);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Fires in the last enabled cycle so the caller leaves after exactly TIMEOUT_CYC cycles.
  assign expired_c = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/ap_host_ctrl.sv
// Job sequencer in front of the associative processor: clear, load A/B, compute, drain C.
module ap_host_ctrl
  import ap_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned CELL_QUANT  = 512,
  parameter int unsigned ADDR_W      = $clog2(CELL_QUANT),
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op_cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_a,
  input  logic [WORD_SIZE-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic                 ap_rst,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_state_irq
);

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e               state;
  op_e                  cmd_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [LAT_W-1:0]     lat_q;
  logic                 last_c;
  logic                 tmo_load_c;
  logic                 tmo_en_c;
  logic                 tmo_expired_c;

  assign last_c     = (ap_addr == ADDR_W'(CELL_QUANT - 1));
  assign tmo_load_c = (state != ST_COMPUTE);
  assign tmo_en_c   = (state == ST_COMPUTE);

  ap_host_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .load     (tmo_load_c),
    .en       (tmo_en_c),
    .expired_c(tmo_expired_c)
  );

  // The A write lands in the handshake cycle itself, so its enable/data follow in_valid directly.
  assign ap_write_en = (state == ST_LOAD_B) | (in_ready & in_valid);
  assign ap_data     = (state == ST_LOAD_B) ? b_q : (in_ready ? in_a : '0);

  // Outputs are registered alongside the state change so they describe the state being entered.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      cmd_q               <= OP_OR;
      b_q                 <= '0;
      lat_q               <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
      in_ready            <= 1'b0;
      out_valid           <= 1'b0;
      out_data            <= '0;
      ap_addr             <= '0;
      ap_rst              <= 1'b0;
      ap_mode             <= 1'b0;
      ap_cmd              <= 3'd0;
      ap_sel_col          <= COL_A;
      ap_sel_internal_col <= 1'b0;
      ap_read_en          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (op_cmd == OP_ILLEGAL) begin
              err <= 1'b1;
            end else begin
              cmd_q               <= op_e'(op_cmd);
              ap_addr             <= '0;
              busy                <= 1'b1;
              ap_rst              <= 1'b1;
              ap_sel_internal_col <= 1'b0;
              state               <= ST_CLR0;
            end
          end
        end
        ST_CLR0: begin
          ap_sel_internal_col <= 1'b1;
          state               <= ST_CLR1;
        end
        ST_CLR1: begin
          ap_rst              <= 1'b0;
          ap_sel_internal_col <= 1'b0;
          in_ready            <= 1'b1;
          ap_sel_col          <= COL_A;
          state               <= ST_LOAD_A;
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            b_q        <= in_b;
            in_ready   <= 1'b0;
            ap_sel_col <= COL_B;
            state      <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          ap_sel_col <= COL_A;
          if (last_c) begin
            ap_addr <= '0;
            ap_mode <= 1'b1;
            ap_cmd  <= cmd_q;
            state   <= ST_COMPUTE;
          end else begin
            ap_addr  <= ap_addr + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= ST_LOAD_A;
          end
        end
        ST_COMPUTE: begin
          if (ap_state_irq) begin
            ap_mode    <= 1'b0;
            ap_cmd     <= 3'd0;
            ap_read_en <= 1'b1;
            ap_sel_col <= COL_C;
            state      <= ST_RD_ISSUE;
          end else if (tmo_expired_c) begin
            ap_mode <= 1'b0;
            ap_cmd  <= 3'd0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          ap_read_en <= 1'b0;
          lat_q      <= '0;
          state      <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) begin
            out_data  <= ap_data_out;
            out_valid <= 1'b1;
            state     <= ST_RD_OUT;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_RD_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_c) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              ap_addr    <= ap_addr + ADDR_W'(1);
              ap_read_en <= 1'b1;
              state      <= ST_RD_ISSUE;
            end
          end
        end
        ST_FIN: begin
          busy       <= 1'b0;
          ap_addr    <= '0;
          ap_sel_col <= COL_A;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ap_host_ctrl.md
# ap_host_ctrl

Job sequencer that sits directly in front of the associative processor (`AP_s`) and drives its full port set. For each job it clears both internal banks, streams operand pairs from a valid/ready source into CAM columns A and B, launches one AP operation, waits for `ap_state_irq`, and drains column C back out as a valid/ready result stream. It replaces the hand-written reset/fill/compute/check sequencing with synthesizable RTL for the FPGA build.

## Interface
Parameters:
- WORD_SIZE, 8, operand/result width
- CELL_QUANT, 512, cells per job (pairs loaded, results returned)
- ADDR_W, $clog2(CELL_QUANT), AP address width
- READ_LAT, 1, cycles from `ap_read_en` asserted to valid `ap_data_out`
- TIMEOUT_CYC, 65535, max cycles waiting for `ap_state_irq`

Ports:
- CLK100MHZ  in  1  sole clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request pulse, sampled in IDLE only
- op_cmd  in  3  OR=0 XOR=1 AND=2 NOT=3 ADD=4 SUB=5 MULT=6; latched on accepted start
- busy  out  1  high from accepted start until `done`/`err`
- done  out  1  one-cycle pulse after last result handshake
- err  out  1  one-cycle pulse: illegal op_cmd (7) or compute timeout
- in_valid / in_ready  in / out  1  operand pair handshake
- in_a, in_b  in  WORD_SIZE  operands for the current cell
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  WORD_SIZE  column C word, ascending address order
- ap_addr  out  ADDR_W;  ap_data  out  WORD_SIZE;  ap_rst  out  1;  ap_mode  out  1;  ap_cmd  out  3
- ap_sel_col  out  2  (0=A, 1=B, 2=C);  ap_sel_internal_col  out  1
- ap_write_en, ap_read_en  out  1
- ap_data_out  in  WORD_SIZE;  ap_state_irq  in  1  AP completion (level, synchronous)

## Operation
- States: IDLE, CLR0, CLR1, LOAD_A, LOAD_B, COMPUTE, RD_ISSUE, RD_WAIT, RD_OUT, FIN.
- IDLE: `start`=1, op_cmd≤6 → latch cmd, cnt=0, CLR0. op_cmd=7 → `err` pulse, stay IDLE.
- CLR0: `ap_rst`=1, sel_internal_col=0, 1 cycle. CLR1: `ap_rst`=1, sel_internal_col=1, 1 cycle → LOAD_A.
- LOAD_A: `in_ready`=1; on handshake register `in_b`, drive write of `in_a` at addr=cnt, sel_col=0 → LOAD_B.
- LOAD_B: `in_ready`=0; write held B at addr=cnt, sel_col=1. cnt==CELL_QUANT-1 → cnt=0, COMPUTE; else cnt++, LOAD_A.
- COMPUTE: `ap_mode`=1, `ap_cmd`=latched cmd; `ap_state_irq`=1 → `ap_mode`=0, RD_ISSUE. Timer reaching TIMEOUT_CYC → `err`, IDLE.
- RD_ISSUE: `ap_read_en`=1, sel_col=2, addr=cnt, 1 cycle. RD_WAIT: READ_LAT cycles; then capture `ap_data_out` → out_data, RD_OUT.
- RD_OUT: `out_valid`=1 until `out_ready`; on handshake cnt==CELL_QUANT-1 → FIN, else cnt++, RD_ISSUE.
- FIN: `done` pulse, IDLE.
- `start` outside IDLE ignored. `sel_internal_col`=0 outside CLR1.

## Timing
- Reset: all outputs 0, state IDLE, cnt 0; `ap_rst` 0.
- Load: 2 cycles per pair min; `in_valid` gaps stall in LOAD_A without side effects.
- `ap_write_en` high only during the LOAD_A-handshake cycle and LOAD_B; address/data/sel_col stable in the same cycle.
- Read: min READ_LAT+2 cycles per result; `out_data`, `out_valid` stable while `out_ready`=0.
- `ap_state_irq` arriving before COMPUTE ignored. cnt wraps only via explicit reset to 0.
- rst_n low mid-job: immediate abort, all outputs 0, no `done`/`err`.

## Structure
- Package `ap_pkg`: op enum (OR..MULT), sel_col constants COL_A/COL_B/COL_C, state enum.
- Sub-module `ap_host_timeout`: loadable down-counter with expire flag for COMPUTE.

## Test plan
- Reset then start op_cmd=4 with CELL_QUANT=4, pairs (1,2)(3,4)(127,1)(0,0) and AP model → outputs 3,7,128,0 then `done`.
- op_cmd=7 start → single `err` pulse, `busy` stays 0, no AP activity.
- `out_ready` held low 10 cycles at result 2 → out_data stable, no read issued, resumes in order.
- AP model never raises `ap_state_irq`, TIMEOUT_CYC=20 → `err` 20 cycles into COMPUTE, `ap_mode` 0.
- rst_n deasserted during LOAD_B of cell 1 → all outputs 0 same cycle, new start runs clean.
- `in_valid` toggling every other cycle, op_cmd=5 (10,3) → write trace A@0=10, B@0=3, result 7.
